// File: rtl/data_mem_sync.sv
// data_mem_sync: single-port word memory with a power-up/on-demand initialisation sweep
// and a latency-1 registered read response with out-of-range error reporting.
module data_mem_sync #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 6,
  parameter int DEPTH     = 32,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_req,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              init_busy
);
  localparam int MW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  generate
    if (DEPTH > 2 ** ADDR_W || DEPTH < 1) begin : g_bad_depth
      $error("data_mem_sync: DEPTH must be in 1..2**ADDR_W");
    end
  endgenerate

  logic [0:0]        state;
  logic [MW-1:0]     init_ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              in_range;
  logic              last;
  logic              mem_we;
  logic [MW-1:0]     idx;
  logic [MW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  assign req_ready = state == RUN;
  assign init_busy = state == INIT;
  assign accept    = req_valid && req_ready;
  assign in_range  = 32'(req_addr) < 32'(DEPTH);
  assign idx       = req_addr[MW-1:0];
  assign last      = init_ptr == MW'(DEPTH - 1);

  // The sweep and the request path share one write port; requests are never accepted in INIT.
  assign mem_we    = state == INIT || (accept && req_we && in_range);
  assign mem_addr  = state == INIT ? init_ptr : idx;
  assign mem_wdata = state == INIT ? (INIT_MODE != 0 ? DATA_W'(init_ptr) : '0) : req_wdata;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      init_ptr <= '0;
    end else if (init_req) begin
      state    <= INIT;
      init_ptr <= '0;
    end else if (state == INIT) begin
      state    <= last ? RUN : INIT;
      init_ptr <= last ? '0 : init_ptr + 1'b1;
    end
  end

  // Out-of-range reads return zero; resp_rdata holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= accept && !req_we;
      resp_err   <= accept && !in_range;
      if (accept && !req_we) resp_rdata <= in_range ? mem[idx] : '0;
    end
  end
endmodule

// File: tb/tb_data_mem_sync.sv
// tb_data_mem_sync: directed checks of sweep timing, read/write, range errors and reset.
module tb_data_mem_sync;
  logic        clk = 1'b0;
  logic        rst;
  logic        init_req;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [5:0]  req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        init_busy;
  logic [15:0] exp_mem [32];
  int          tests = 0;
  int          fails = 0;

  data_mem_sync dut (
    .clk(clk), .rst(rst), .init_req(init_req), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic we, input logic [5:0] a, input logic [15:0] d, input logic ir);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    init_req  = ir;
    @(negedge clk);
    req_valid = 1'b0;
    init_req  = 1'b0;
  endtask

  task automatic identity_model();
    for (int i = 0; i < 32; i++) exp_mem[i] = 16'(i);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", init_busy); end
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", resp_err); end
    tests++; if (resp_rdata !== 16'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0000", resp_rdata); end
    rst = 1'b0;
    begin
      int n = 0;
      while (init_busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      tests++; if (n != 32) begin fails++; $display("FAIL reset_sweep_len: got %0d want 32", n); end
    end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL run_ready: got %b want 1", req_ready); end
    identity_model();
    for (int i = 0; i < 32; i++) begin
      issue(1'b0, 6'(i), 16'h0, 1'b0);
      tests++; if (resp_valid !== 1'b1 || resp_rdata !== exp_mem[i] || resp_err !== 1'b0) begin
        fails++; $display("FAIL reset_read[%0d]: got v=%b e=%b d=%h want v=1 e=0 d=%h", i, resp_valid, resp_err, resp_rdata, exp_mem[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'(i);
      @(negedge clk);
      tests++; if (resp_valid !== 1'b1 || resp_rdata !== exp_mem[i]) begin
        fails++; $display("FAIL b2b[%0d]: got v=%b d=%h want v=1 d=%h", i, resp_valid, resp_rdata, exp_mem[i]);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
    tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: got v=%b want 0", resp_valid); end
  endtask

  task automatic test_write_read();
    issue(1'b1, 6'd5, 16'hBEEF, 1'b0);
    exp_mem[5] = 16'hBEEF;
    tests++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin
      fails++; $display("FAIL wr_noresp: got v=%b e=%b want v=0 e=0", resp_valid, resp_err);
    end
    issue(1'b0, 6'd5, 16'h0, 1'b0);
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 16'hBEEF) begin
      fails++; $display("FAIL raw: got v=%b d=%h want v=1 d=beef", resp_valid, resp_rdata);
    end
    @(negedge clk);
    tests++; if (resp_valid !== 1'b0 || resp_rdata !== 16'hBEEF) begin
      fails++; $display("FAIL hold: got v=%b d=%h want v=0 d=beef", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_oob();
    issue(1'b0, 6'd40, 16'h0, 1'b0);
    tests++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 16'h0) begin
      fails++; $display("FAIL oob_read: got v=%b e=%b d=%h want v=1 e=1 d=0000", resp_valid, resp_err, resp_rdata);
    end
    issue(1'b1, 6'd40, 16'h1234, 1'b0);
    tests++; if (resp_valid !== 1'b0 || resp_err !== 1'b1) begin
      fails++; $display("FAIL oob_write: got v=%b e=%b want v=0 e=1", resp_valid, resp_err);
    end
    @(negedge clk);
    tests++; if (resp_err !== 1'b0) begin fails++; $display("FAIL oob_pulse: got e=%b want 0", resp_err); end
    for (int i = 0; i < 32; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'(i);
      @(negedge clk);
      tests++; if (resp_valid !== 1'b1 || resp_err !== 1'b0 || resp_rdata !== exp_mem[i]) begin
        fails++; $display("FAIL oob_sweep[%0d]: got v=%b e=%b d=%h want v=1 e=0 d=%h", i, resp_valid, resp_err, resp_rdata, exp_mem[i]);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_init_req();
    issue(1'b1, 6'd3, 16'hAAAA, 1'b0);
    issue(1'b0, 6'd3, 16'h0, 1'b1);
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 16'hAAAA) begin
      fails++; $display("FAIL initreq_accept: got v=%b d=%h want v=1 d=aaaa", resp_valid, resp_rdata);
    end
    begin
      int n = 0;
      while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      tests++; if (n != 32) begin fails++; $display("FAIL initreq_len: got %0d want 32", n); end
    end
    identity_model();
    issue(1'b0, 6'd3, 16'h0, 1'b0);
    tests++; if (resp_valid !== 1'b1 || resp_rdata !== 16'h0003) begin
      fails++; $display("FAIL initreq_restore: got v=%b d=%h want v=1 d=0003", resp_valid, resp_rdata);
    end
  endtask

  task automatic test_rst_mid_read();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 6'd4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL midread_pre: got v=%b want 1", resp_valid); end
    rst = 1'b1;
    #1;
    tests++; if (resp_valid !== 1'b0 || resp_rdata !== 16'h0 || init_busy !== 1'b1 || req_ready !== 1'b0) begin
      fails++; $display("FAIL midread_rst: got v=%b d=%h busy=%b rdy=%b want v=0 d=0000 busy=1 rdy=0", resp_valid, resp_rdata, init_busy, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    begin
      int n = 0;
      while (init_busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      tests++; if (n != 32) begin fails++; $display("FAIL midread_len: got %0d want 32", n); end
    end
  endtask

  task automatic test_rst_mid_sweep();
    issue(1'b1, 6'd9, 16'h5555, 1'b0);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if (init_busy !== 1'b1 || req_ready !== 1'b0) begin
      fails++; $display("FAIL midsweep_rst: got busy=%b rdy=%b want busy=1 rdy=0", init_busy, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    begin
      int n = 0;
      while (init_busy !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      tests++; if (n != 32) begin fails++; $display("FAIL midsweep_len: got %0d want 32", n); end
    end
    identity_model();
    for (int i = 0; i < 32; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'(i);
      @(negedge clk);
      tests++; if (resp_valid !== 1'b1 || resp_rdata !== exp_mem[i]) begin
        fails++; $display("FAIL midsweep_read[%0d]: got v=%b d=%h want v=1 d=%h", i, resp_valid, resp_rdata, exp_mem[i]);
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; init_req = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_write_read();
    test_oob();
    test_init_req();
    test_rst_mid_read();
    test_rst_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_mem_sync.md
DATA_MEM_SYNC -- requirements
Module: data_mem_sync

Interface
REQ-001 Parameter DATA_W, default 16, data word width in bits.
REQ-002 Parameter ADDR_W, default 6, address width in bits.
REQ-003 Parameter DEPTH, default 32, number of words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter INIT_MODE, default 1; 0 = all words zero, 1 = word i holds i (truncated to DATA_W).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 init_req  in  1  pulse; re-runs the initialisation sweep.
REQ-008 req_valid  in  1  request present.
REQ-009 req_ready  out  1  block accepts a request this cycle.
REQ-010 req_we  in  1  1 = write, 0 = read.
REQ-011 req_addr  in  ADDR_W  word address.
REQ-012 req_wdata  in  DATA_W  write data.
REQ-013 resp_valid  out  1  read data valid, one-cycle pulse per accepted read.
REQ-014 resp_rdata  out  DATA_W  read data.
REQ-015 resp_err  out  1  accepted request had req_addr >= DEPTH; qualified by resp_valid for reads, pulses alone for writes.
REQ-016 init_busy  out  1  initialisation sweep in progress.

Function
REQ-017 The FSM SHALL have states INIT and RUN.
REQ-018 INIT SHALL write one word per cycle using counter init_ptr, from 0 to DEPTH-1, with the value set by INIT_MODE.
REQ-019 INIT SHALL go to RUN on the cycle after word DEPTH-1 is written, so the sweep takes exactly DEPTH cycles.
REQ-020 In INIT: init_busy=1, req_ready=0, and no request SHALL be accepted.
REQ-021 In RUN: req_ready=1 and init_busy=0.
REQ-022 init_req=1 in RUN SHALL move the FSM to INIT with init_ptr=0 on the next edge; any request in that same cycle SHALL be accepted first.
REQ-023 init_req during INIT SHALL restart the sweep at init_ptr=0.
REQ-024 A request is accepted when req_valid && req_ready at a rising edge.
REQ-025 Accepted in-range write: mem[req_addr] <= req_wdata at that edge; no resp_valid.
REQ-026 Accepted in-range read: resp_valid=1 and resp_rdata=mem[req_addr] in the following cycle (latency 1, registered output).
REQ-027 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-028 The block SHALL accept back-to-back reads every cycle at full throughput; there is no response back-pressure.
REQ-029 Out-of-range write SHALL be discarded (memory unchanged) and SHALL pulse resp_err with resp_valid=0 the next cycle.
REQ-030 Out-of-range read SHALL give resp_valid=1, resp_err=1 and resp_rdata=0 the next cycle.
REQ-031 resp_rdata SHALL hold its last value when resp_valid=0.
REQ-032 Reads SHALL be side-effect free; the write path SHALL never be driven from an output port.

Reset
REQ-033 rst=1 SHALL immediately force: state=INIT, init_ptr=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=0, init_busy=1.
REQ-034 Memory contents are not reset directly; after rst deasserts, the sweep SHALL restore them (DEPTH cycles).
REQ-035 rst asserted mid-sweep or mid-read SHALL drop any pending response and restart the sweep from 0.

Verification
REQ-036 Reset release, defaults: wait until init_busy=0 -> exactly 32 cycles; reads 0..31 return 0..31, each with 1-cycle latency.
REQ-037 Write addr 5 = 0xBEEF, then read addr 5 on the next cycle -> resp_valid=1 and resp_rdata=0xBEEF one cycle after the read is accepted.
REQ-038 Read addr 40 -> resp_valid=1, resp_err=1, resp_rdata=0. Write addr 40 = 0x1234 -> resp_err pulse only; a full read sweep shows no change.
REQ-039 Write addr 3 = 0xAAAA, then pulse init_req -> req_ready=0 for 32 cycles; then read addr 3 returns 3.
REQ-040 Assert rst at sweep cycle 10, release -> init_busy stays high for a further 32 full cycles; then reads of all 32 words are correct.
REQ-041 Ten back-to-back reads of addresses 0..9 -> ten consecutive resp_valid cycles, data 0..9 in order.
